// File: rtl/operand_pkg.sv
// Shared types for the decoder, operand stage and ALU.
// Forwarding is selected with OPERAND_STAGE_FORWARD_EN.
package operand_pkg;

    localparam int W    = 8;
    localparam int NREG = 8;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0] reg_addr_t;

    typedef enum logic [3:0] {
        XOR  = 4'd0,
        ADD  = 4'd1,
        SUB  = 4'd2,
        SGN  = 4'd3,
        NOT  = 4'd4,
        POPC = 4'd5,
        LTA  = 4'd6,
        LTB  = 4'd7,
        MOV  = 4'd8,
        SHI  = 4'd9,
        ADDI = 4'd10,
        SUBI = 4'd11
    } alu_op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    function automatic logic [NREG-1:0] addr_onehot(input reg_addr_t a);
        return {{(NREG-1){1'b0}}, 1'b1} << a;
    endfunction

endpackage

// File: rtl/reg_file.sv
// NREG x W register file: two async read ports, one sync write port.
// Asynchronous reset clears every entry.
module reg_file
    import operand_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  reg_addr_t     i_rd_addr_a,
    input  reg_addr_t     i_rd_addr_b,
    output logic [W-1:0]  o_rd_data_a,
    output logic [W-1:0]  o_rd_data_b,
    input  logic          i_wr_en,
    input  reg_addr_t     i_wr_addr,
    input  logic [W-1:0]  i_wr_data
);

    logic [W-1:0] r_mem [NREG];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data_a = r_mem[i_rd_addr_a];
    assign o_rd_data_b = r_mem[i_rd_addr_b];

endmodule

// File: rtl/operand_stage.sv
// Register-read/issue stage ahead of the ALU with a pending-write scoreboard.
// OPERAND_STAGE_FORWARD_EN bypasses same-cycle writeback data into issue.
module operand_stage
    import operand_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic            InValid,
    output logic            InReady,
    input  logic [3:0]      InAluop,
    input  logic [2:0]      InImm,
    input  reg_addr_t       InRa,
    input  reg_addr_t       InRb,
    input  reg_addr_t       InRd,
    input  logic            InWr,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [3:0]      Aluop,
    output logic [2:0]      Imm,
    output logic [W-1:0]    DatA,
    output logic [W-1:0]    DatB,
    output reg_addr_t       OutRd,
    output logic            OutWr,
    input  logic            WbEn,
    input  reg_addr_t       WbAddr,
    input  logic [W-1:0]    WbData,
    output logic [NREG-1:0] Busy
);

    out_state_e      r_state;
    logic [NREG-1:0] r_busy;
    logic [3:0]      r_aluop;
    logic [2:0]      r_imm;
    logic [W-1:0]    r_dat_a;
    logic [W-1:0]    r_dat_b;
    reg_addr_t       r_rd;
    logic            r_wr;

    logic [W-1:0]    w_rf_a;
    logic [W-1:0]    w_rf_b;
    logic [W-1:0]    w_op_a;
    logic [W-1:0]    w_op_b;
    logic [NREG-1:0] w_wb_hit;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_busy_eff;
    logic            w_hazard;
    logic            w_accept;

    reg_file u_rf (
        .i_clk       (Clk),
        .i_rst       (Reset),
        .i_rd_addr_a (InRa),
        .i_rd_addr_b (InRb),
        .o_rd_data_a (w_rf_a),
        .o_rd_data_b (w_rf_b),
        .i_wr_en     (WbEn),
        .i_wr_addr   (WbAddr),
        .i_wr_data   (WbData)
    );

    assign w_wb_hit = WbEn ? addr_onehot(WbAddr) : '0;

`ifdef OPERAND_STAGE_FORWARD_EN
    // A register being written back this cycle is no longer a hazard.
    assign w_busy_eff = r_busy & ~w_wb_hit;
    assign w_op_a = (WbEn && WbAddr == InRa) ? WbData : w_rf_a;
    assign w_op_b = (WbEn && WbAddr == InRb) ? WbData : w_rf_b;
`else
    assign w_busy_eff = r_busy;
    assign w_op_a = w_rf_a;
    assign w_op_b = w_rf_b;
`endif

    assign w_hazard = w_busy_eff[InRa]
                    | w_busy_eff[InRb]
                    | (InWr & w_busy_eff[InRd]);

    assign OutValid = (r_state == FULL);
    assign InReady  = (!OutValid | OutReady) & !w_hazard;
    assign w_accept = InValid & InReady;
    assign w_set    = (w_accept & InWr) ? addr_onehot(InRd) : '0;

    // Set is applied after clear so a new producer wins over a writeback.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_wb_hit) | w_set;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= EMPTY;
            r_aluop <= '0;
            r_imm   <= '0;
            r_dat_a <= '0;
            r_dat_b <= '0;
            r_rd    <= '0;
            r_wr    <= 1'b0;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (!w_accept && OutReady) begin
                        r_state <= EMPTY;
                    end
                end
            endcase
            if (w_accept) begin
                r_aluop <= InAluop;
                r_imm   <= InImm;
                r_dat_a <= w_op_a;
                r_dat_b <= w_op_b;
                r_rd    <= InRd;
                r_wr    <= InWr;
            end
        end
    end

    assign Aluop = r_aluop;
    assign Imm   = r_imm;
    assign DatA  = r_dat_a;
    assign DatB  = r_dat_b;
    assign OutRd = r_rd;
    assign OutWr = r_wr;
    assign Busy  = r_busy;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage; adapts to OPERAND_STAGE_FORWARD_EN.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_operand_stage;
    import operand_pkg::*;

    logic            Clk;
    logic            Reset;
    logic            InValid;
    logic            InReady;
    logic [3:0]      InAluop;
    logic [2:0]      InImm;
    reg_addr_t       InRa;
    reg_addr_t       InRb;
    reg_addr_t       InRd;
    logic            InWr;
    logic            OutValid;
    logic            OutReady;
    logic [3:0]      Aluop;
    logic [2:0]      Imm;
    logic [W-1:0]    DatA;
    logic [W-1:0]    DatB;
    reg_addr_t       OutRd;
    logic            OutWr;
    logic            WbEn;
    reg_addr_t       WbAddr;
    logic [W-1:0]    WbData;
    logic [NREG-1:0] Busy;

    int checks = 0;
    int errors = 0;

    operand_stage dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .InAluop  (InAluop),
        .InImm    (InImm),
        .InRa     (InRa),
        .InRb     (InRb),
        .InRd     (InRd),
        .InWr     (InWr),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Aluop    (Aluop),
        .Imm      (Imm),
        .DatA     (DatA),
        .DatB     (DatB),
        .OutRd    (OutRd),
        .OutWr    (OutWr),
        .WbEn     (WbEn),
        .WbAddr   (WbAddr),
        .WbData   (WbData),
        .Busy     (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] imm,
                         input int ra, input int rb,
                         input int rd, input logic wr);
        InValid = 1'b1;
        InAluop = op;
        InImm   = imm;
        InRa    = reg_addr_t'(ra);
        InRb    = reg_addr_t'(rb);
        InRd    = reg_addr_t'(rd);
        InWr    = wr;
    endtask

    task automatic idle();
        InValid = 1'b0;
        InWr    = 1'b0;
    endtask

    task automatic wb(input int a, input logic [7:0] d);
        WbEn   = 1'b1;
        WbAddr = reg_addr_t'(a);
        WbData = d;
    endtask

    task automatic nowb();
        WbEn = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", OutValid); end
        checks++; if (Busy !== 8'h00) begin errors++; $display("FAIL rst_busy got %h exp 00", Busy); end
        checks++; if (DatA !== 8'h00 || DatB !== 8'h00) begin errors++; $display("FAIL rst_dat got %h/%h exp 00/00", DatA, DatB); end
        checks++; if (Aluop !== 4'h0 || Imm !== 3'h0 || OutRd !== 3'h0 || OutWr !== 1'b0) begin errors++; $display("FAIL rst_fields got %h/%h/%h/%b exp 0", Aluop, Imm, OutRd, OutWr); end
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL rst_inready got %b exp 1", InReady); end
    endtask

    task automatic test_issue();
        wb(1, 8'h05); tick();
        wb(2, 8'h03); tick();
        nowb();
        drive(ADD, 3'd0, 1, 2, 3, 1'b1);
        #1;
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL issue_ready got %b exp 1", InReady); end
        tick(); idle();
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL issue_valid got %b exp 1", OutValid); end
        checks++; if (DatA !== 8'h05) begin errors++; $display("FAIL issue_data got %h exp 05", DatA); end
        checks++; if (DatB !== 8'h03) begin errors++; $display("FAIL issue_datb got %h exp 03", DatB); end
        checks++; if (Aluop !== 4'd1) begin errors++; $display("FAIL issue_aluop got %h exp 1", Aluop); end
        checks++; if (Busy !== 8'h08) begin errors++; $display("FAIL issue_busy got %h exp 08", Busy); end
        checks++; if (OutRd !== 3'd3 || OutWr !== 1'b1) begin errors++; $display("FAIL issue_tag got %h/%b exp 3/1", OutRd, OutWr); end
        tick();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL issue_drain got %b exp 0", OutValid); end
    endtask

    task automatic test_raw();
        wb(3, 8'h00); tick(); nowb();
        drive(ADD, 3'd0, 1, 2, 3, 1'b1);
        tick();
        drive(SUB, 3'd0, 3, 1, 5, 1'b0);
        #1;
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL raw_stall got %b exp 0", InReady); end
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL raw_prod_valid got %b exp 1", OutValid); end
        tick();
        checks++; if (OutValid !== 1'b0 || InReady !== 1'b0) begin errors++; $display("FAIL raw_hold got %b/%b exp 0/0", OutValid, InReady); end
        wb(3, 8'h08);
        #1;
`ifdef OPERAND_STAGE_FORWARD_EN
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL raw_fwd_ready got %b exp 1", InReady); end
        tick(); nowb(); idle();
`else
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL raw_wb_ready got %b exp 0", InReady); end
        tick(); nowb();
        #1;
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL raw_next_ready got %b exp 1", InReady); end
        tick(); idle();
`endif
        checks++; if (OutValid !== 1'b1 || Aluop !== 4'd2) begin errors++; $display("FAIL raw_issue got %b/%h exp 1/2", OutValid, Aluop); end
        checks++; if (DatA !== 8'h08 || DatB !== 8'h05) begin errors++; $display("FAIL raw_data got %h/%h exp 08/05", DatA, DatB); end
        checks++; if (Busy !== 8'h00) begin errors++; $display("FAIL raw_busy got %h exp 00", Busy); end
        tick();
    endtask

    task automatic test_backpressure();
        OutReady = 1'b0;
        drive(MOV, 3'd5, 1, 2, 0, 1'b0);
        tick();
        drive(XOR, 3'd0, 2, 1, 7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (InReady !== 1'b0 || OutValid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got %b/%b exp 0/1", i, InReady, OutValid); end
            checks++; if (Aluop !== 4'd8 || Imm !== 3'd5 || DatA !== 8'h05 || DatB !== 8'h03) begin errors++; $display("FAIL bp_stable%0d got %h/%h/%h/%h exp 8/5/05/03", i, Aluop, Imm, DatA, DatB); end
            tick();
        end
        OutReady = 1'b1;
        #1;
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", InReady); end
        tick(); idle();
        checks++; if (OutValid !== 1'b1 || Aluop !== 4'd0 || OutRd !== 3'd7) begin errors++; $display("FAIL bp_b2b got %b/%h/%h exp 1/0/7", OutValid, Aluop, OutRd); end
        checks++; if (DatA !== 8'h03 || DatB !== 8'h05) begin errors++; $display("FAIL bp_b2b_data got %h/%h exp 03/05", DatA, DatB); end
        tick();
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", OutValid); end
    endtask

    task automatic test_waw();
        drive(ADD, 3'd0, 1, 2, 4, 1'b1);
        tick();
        drive(ADDI, 3'd2, 1, 1, 4, 1'b1);
        #1;
        checks++; if (InReady !== 1'b0 || Busy !== 8'h10) begin errors++; $display("FAIL waw_stall got %b/%h exp 0/10", InReady, Busy); end
        tick();
        checks++; if (OutValid !== 1'b0 || Busy !== 8'h10) begin errors++; $display("FAIL waw_hold got %b/%h exp 0/10", OutValid, Busy); end
        wb(4, 8'h11);
        #1;
`ifdef OPERAND_STAGE_FORWARD_EN
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL waw_fwd_ready got %b exp 1", InReady); end
        tick(); nowb(); idle();
`else
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL waw_wb_ready got %b exp 0", InReady); end
        tick(); nowb();
        checks++; if (Busy !== 8'h00) begin errors++; $display("FAIL waw_cleared got %h exp 00", Busy); end
        tick(); idle();
`endif
        checks++; if (OutValid !== 1'b1 || Aluop !== 4'd10) begin errors++; $display("FAIL waw_issue got %b/%h exp 1/a", OutValid, Aluop); end
        checks++; if (Busy !== 8'h10) begin errors++; $display("FAIL waw_busy got %h exp 10", Busy); end
        wb(4, 8'h22); tick(); nowb();
        checks++; if (Busy !== 8'h00) begin errors++; $display("FAIL waw_clear got %h exp 00", Busy); end
        drive(ADD, 3'd0, 1, 2, 4, 1'b1);
        wb(4, 8'h33);
        #1;
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL setwin_ready got %b exp 1", InReady); end
        tick(); idle(); nowb();
        checks++; if (Busy !== 8'h10) begin errors++; $display("FAIL setwin_busy got %h exp 10", Busy); end
        wb(4, 8'h00); tick(); nowb();
        checks++; if (Busy !== 8'h00) begin errors++; $display("FAIL waw_final got %h exp 00", Busy); end
    endtask

    task automatic test_wb_nonbusy();
        wb(6, 8'hAA); tick(); nowb();
        checks++; if (Busy !== 8'h00) begin errors++; $display("FAIL nb_busy got %h exp 00", Busy); end
        drive(MOV, 3'd0, 6, 6, 0, 1'b0);
        tick(); idle();
        checks++; if (DatA !== 8'hAA || DatB !== 8'hAA) begin errors++; $display("FAIL nb_data got %h/%h exp aa/aa", DatA, DatB); end
        checks++; if (Busy !== 8'h00) begin errors++; $display("FAIL nb_busy2 got %h exp 00", Busy); end
        tick();
    endtask

    task automatic test_reset_midop();
        OutReady = 1'b0;
        drive(ADD, 3'd0, 1, 2, 3, 1'b1);
        tick(); idle();
        checks++; if (OutValid !== 1'b1 || Busy !== 8'h08) begin errors++; $display("FAIL mr_pre got %b/%h exp 1/08", OutValid, Busy); end
        Reset = 1'b1;
        #1;
        checks++; if (OutValid !== 1'b0 || Busy !== 8'h00) begin errors++; $display("FAIL mr_clear got %b/%h exp 0/00", OutValid, Busy); end
        checks++; if (DatA !== 8'h00 || InReady !== 1'b1) begin errors++; $display("FAIL mr_out got %h/%b exp 00/1", DatA, InReady); end
        #1;
        Reset = 1'b0;
        OutReady = 1'b1;
        wb(3, 8'h44); tick(); nowb();
        checks++; if (Busy !== 8'h00) begin errors++; $display("FAIL mr_late_busy got %h exp 00", Busy); end
        drive(MOV, 3'd0, 1, 3, 0, 1'b0);
        tick(); idle();
        checks++; if (DatA !== 8'h00) begin errors++; $display("FAIL mr_r1 got %h exp 00", DatA); end
        checks++; if (DatB !== 8'h44) begin errors++; $display("FAIL mr_late_wb got %h exp 44", DatB); end
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset    = 1'b1;
        InValid  = 1'b0;
        InAluop  = '0;
        InImm    = '0;
        InRa     = '0;
        InRb     = '0;
        InRd     = '0;
        InWr     = 1'b0;
        OutReady = 1'b1;
        WbEn     = 1'b0;
        WbAddr   = '0;
        WbData   = '0;
        #12;
        Reset = 1'b0;
        #1;
        test_reset();
        test_issue();
        test_raw();
        test_backpressure();
        test_waw();
        test_wb_nonbusy();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
